// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and bit-timing constants (used by uart_rx and uart_tx)
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] FULL_TICK = 4'd15;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver bus; master drives tick/rx, slave (uart_rx) returns dout, rx_done_tick, frame_err, parity_err
interface uart_rx_if;
  logic       tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  modport master (output tick, rx, input dout, rx_done_tick, frame_err, parity_err);
  modport slave  (input tick, rx, output dout, rx_done_tick, frame_err, parity_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer; ports clk, reset (async active-low), d, q; flops reset to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ff_q <= {2{RST_VAL}};
    else        ff_q <= {ff_q[0], d};
  assign q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver with DBIT data bits and SB_TICK-tick stop period
// Ports: clk, reset (async active-low), bus (uart_rx_if.slave: tick, rx in; dout, rx_done_tick, frame_err, parity_err out)
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined; otherwise parity_err is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  // stop period may exceed 16 ticks (two stop bits), so the tick counter grows with it
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [7:0]      dout_q, dout_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            pe_q, pe_d;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(bus.rx), .q(rx_s));
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    fe_d    = fe_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    case (state_q)
      IDLE:
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      START:
        if (bus.tick) begin
          if (s_q == SW'(MID_TICK)) begin
            // line back high at mid start bit is a glitch, not a frame
            state_d = rx_s ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else s_d = s_q + SW'(1);
        end
      DATA:
        if (bus.tick) begin
          if (s_q == SW'(FULL_TICK)) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == 3'(DBIT - 1))
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            else n_d = n_q + 3'd1;
          end else s_d = s_q + SW'(1);
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (bus.tick) begin
          if (s_q == SW'(FULL_TICK)) begin
            par_d   = rx_s ^ (^b_q);
            s_d     = '0;
            state_d = STOP;
          end else s_d = s_q + SW'(1);
        end
`endif
      STOP:
        if (bus.tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            fe_d    = ~rx_s;
            dout_d  = 8'(b_q);
`ifdef UART_RX_PARITY_EN
            pe_d    = par_q;
`endif
          end else s_d = s_q + SW'(1);
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = fe_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = pe_q;
`else
  assign bus.parity_err   = 1'b0;
`endif
endmodule
